// File: rtl/uart_wb_bridge_if.sv
// uart_wb_bridge_if: serial pins plus classic Wishbone master bus of the UART bridge.
interface uart_wb_bridge_if;
    logic        uart_rx;
    logic        uart_tx;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    modport master (
        input  uart_rx, wb_dat_r, wb_ack,
        output uart_tx, wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
    );
    modport slave (
        output uart_rx, wb_dat_r, wb_ack,
        input  uart_tx, wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
    );
endinterface

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: 8N1 UART command frames to Wishbone word reads/writes, read data echoed on TX.
// Define UART_WB_BRIDGE_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module uart_wb_bridge #(
    parameter int CLKS_PER_BIT   = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic clk,
    input logic rst,
    uart_wb_bridge_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [2:0] {IDLE, LEN, ADDR, WDATA, BUS_WR, BUS_RD, TX_DATA} state_t;
    state_t state_q, state_d;
    logic rx_s1_q, rx_s2_q, rx_prev_q, rx_busy_q, rx_busy_d, rx_full_q, rx_full_d, rx_good;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [3:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d, len_q, len_d;
    logic [9:0] tx_sh_q, tx_sh_d;
    logic [2:0] cnt_q, cnt_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic wr_q, wr_d, cyc_q, cyc_d, consume, tx_load, frame, timeout;
    assign frame = state_q inside {LEN, ADDR, WDATA};
    assign consume = rx_full_q && (frame || state_q == IDLE);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
    assign to_d = (frame && !consume) ? to_q + 1'b1 : '0;
    assign timeout = frame && !consume && to_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) to_q <= rst ? '0 : to_d;
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif
    // Sync flops reset low so a line already low after reset cannot look like a start edge.
    always_comb begin
        rx_busy_d = rx_busy_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_good = 1'b0;
        if (!rx_busy_q) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_busy_d = 1'b1;
                rx_cnt_d = HALF;
                rx_bit_d = 4'd0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
            rx_cnt_d = BIT_LAST;
            rx_bit_d = rx_bit_q + 4'd1;
            if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9) rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 4'd9) begin
                rx_busy_d = 1'b0;
                rx_good = rx_s2_q;
            end
        end
        rx_full_d = rx_good | (rx_full_q & ~consume);
        rx_byte_d = (rx_good && (!rx_full_q || consume)) ? rx_sh_q : rx_byte_q;
    end
    always_comb begin
        tx_sh_d = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_load) begin
            tx_sh_d = {1'b1, dat_q[31:24], 1'b0};
            tx_bit_d = 4'd10;
            tx_cnt_d = BIT_LAST;
        end else if (tx_bit_q != 4'd0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
            if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_LAST;
                tx_sh_d = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q - 4'd1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        cnt_d = cnt_q;
        adr_d = adr_q;
        dat_d = dat_q;
        wr_d = wr_q;
        cyc_d = cyc_q;
        tx_load = 1'b0;
        case (state_q)
            IDLE: if (consume && (rx_byte_q == 8'h01 || rx_byte_q == 8'h02)) begin
                wr_d = rx_byte_q[0];
                state_d = LEN;
            end
            LEN: if (consume) begin
                len_d = rx_byte_q;
                cnt_d = '0;
                state_d = ADDR;
            end
            ADDR: if (consume) begin
                adr_d = {adr_q[21:0], rx_byte_q};
                cnt_d = cnt_q == 3'd3 ? 3'd0 : cnt_q + 3'd1;
                if (cnt_q == 3'd3) state_d = len_q == 8'd0 ? IDLE : wr_q ? WDATA : BUS_RD;
            end
            WDATA: if (consume) begin
                dat_d = {dat_q[23:0], rx_byte_q};
                cnt_d = cnt_q == 3'd3 ? 3'd0 : cnt_q + 3'd1;
                if (cnt_q == 3'd3) state_d = BUS_WR;
            end
            BUS_WR, BUS_RD: begin
                cyc_d = 1'b1;
                if (cyc_q && bus.wb_ack) begin
                    cyc_d = 1'b0;
                    adr_d = adr_q + 30'd1;
                    len_d = len_q - 8'd1;
                    dat_d = state_q == BUS_RD ? bus.wb_dat_r : dat_q;
                    state_d = state_q == BUS_RD ? TX_DATA : len_q == 8'd1 ? IDLE : WDATA;
                end
            end
            TX_DATA: if (tx_bit_q == 4'd0) begin
                if (cnt_q == 3'd4) begin
                    cnt_d = '0;
                    state_d = len_q == 8'd0 ? IDLE : BUS_RD;
                end else begin
                    tx_load = 1'b1;
                    cnt_d = cnt_q + 3'd1;
                    dat_d = {dat_q[23:0], 8'h00};
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            cnt_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_s1_q, rx_s2_q, rx_prev_q, rx_busy_q, rx_full_q} <= '0;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q <= '0;
            rx_byte_q <= '0;
            tx_sh_q <= '1;
            tx_bit_q <= '0;
            tx_cnt_q <= '0;
            state_q <= IDLE;
            len_q <= '0;
            cnt_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            wr_q <= 1'b0;
            cyc_q <= 1'b0;
        end else begin
            rx_s1_q <= bus.uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_busy_q <= rx_busy_d;
            rx_full_q <= rx_full_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d;
            rx_byte_q <= rx_byte_d;
            tx_sh_q <= tx_sh_d;
            tx_bit_q <= tx_bit_d;
            tx_cnt_q <= tx_cnt_d;
            state_q <= state_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            wr_q <= wr_d;
            cyc_q <= cyc_d;
        end
    end
    assign bus.uart_tx = tx_sh_q[0];
    assign bus.wb_adr = adr_q;
    assign bus.wb_dat_w = dat_q;
    assign bus.wb_sel = 4'hF;
    assign bus.wb_cyc = cyc_q;
    assign bus.wb_stb = cyc_q;
    assign bus.wb_we = cyc_q & wr_q;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: table-driven frames plus garbage, reset and timeout sequences for uart_wb_bridge.
module tb_uart_wb_bridge;
    localparam int CPB = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic hold_ack = 1'b0, stray_ack = 1'b0, mon_en = 1'b0;
    logic [29:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    logic [3:0]  log_sel[$];
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  mb;
    typedef struct {
        logic        wr;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [29:0] ea0;
        logic [29:0] ea1;
    } vec_t;
    vec_t vt[6];

    uart_wb_bridge_if bus();
    uart_wb_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(1000)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rx_bit(input logic v);
        bus.uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic wr, input logic [7:0] len, input logic [31:0] a,
                              input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] dw;
        send(wr ? 8'h01 : 8'h02, 1'b1);
        send(len, 1'b1);
        for (int i = 3; i >= 0; i--) send(a[8*i +: 8], 1'b1);
        if (wr) for (int w = 0; w < int'(len); w++) begin
            dw = (w == 0) ? d0 : d1;
            for (int i = 3; i >= 0; i--) send(dw[8*i +: 8], 1'b1);
        end
        bus.uart_rx = 1'b1;
    endtask

    task automatic wait_for(input int nbus, input int ntx, input int budget);
        for (int c = 0; c < budget && !(log_adr.size() >= nbus && tx_q.size() >= ntx); c++) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_adr.delete();
        log_dat.delete();
        log_we.delete();
        log_sel.delete();
        tx_q.delete();
        rd_q.delete();
    endtask

    task automatic check_read(input string tag, input logic [29:0] ea, input logic [31:0] d);
        chk({tag, "_bus_count"}, 32'(log_adr.size()), 32'd1);
        chk({tag, "_tx_count"}, 32'(tx_q.size()), 32'd4);
        if (log_adr.size() > 0) begin
            chk({tag, "_adr"}, 32'(log_adr[0]), 32'(ea));
            chk({tag, "_we"}, 32'(log_we[0]), 32'd0);
        end
        for (int b = 0; b < 4 && b < tx_q.size(); b++) chk({tag, "_tx_byte"}, 32'(tx_q[b]), 32'(d[31-8*b -: 8]));
    endtask

    // Wishbone slave: single-cycle ack one cycle after cyc/stb, logs every acknowledged cycle.
    initial begin
        bus.wb_ack = 1'b0;
        bus.wb_dat_r = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.wb_cyc && bus.wb_stb && !bus.wb_ack && !hold_ack) begin
                log_adr.push_back(bus.wb_adr);
                log_dat.push_back(bus.wb_dat_w);
                log_we.push_back(bus.wb_we);
                log_sel.push_back(bus.wb_sel);
                bus.wb_dat_r = rd_q.size() > 0 ? rd_q.pop_front() : 32'hDEAD_0000;
                bus.wb_ack = 1'b1;
            end else begin
                bus.wb_ack = stray_ack;
            end
        end
    end

    // UART TX decoder sampling at mid-bit on the falling clock edge.
    initial forever begin
        @(negedge bus.uart_tx);
        if (mon_en) begin
            repeat (3) @(negedge clk);
            chk("tx_start_bit", 32'(bus.uart_tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mb[i] = bus.uart_tx;
            end
            repeat (CPB) @(negedge clk);
            chk("tx_stop_bit", 32'(bus.uart_tx), 32'd1);
            tx_q.push_back(mb);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] ea;
        logic [31:0] ed;
        vt[0] = '{1'b1, 8'd1, 32'h0400_0000, 32'h1234_5678, 32'h0000_0000, 30'h400_0000, 30'h0};
        vt[1] = '{1'b0, 8'd1, 32'h0400_0003, 32'h1234_5678, 32'h0000_0000, 30'h400_0003, 30'h0};
        vt[2] = '{1'b0, 8'd2, 32'h3FFF_FFFF, 32'hFACE_CA8C, 32'h0A0A_0A0A, 30'h3FFF_FFFF, 30'h0};
        vt[3] = '{1'b1, 8'd2, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0001, 30'h3FFF_FFFF, 30'h0};
        vt[4] = '{1'b1, 8'd1, 32'h8000_0010, 32'hA5A5_5A5A, 32'h0000_0000, 30'h10, 30'h0};
        vt[5] = '{1'b0, 8'd0, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 30'h0, 30'h0};
        bus.uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart_tx", 32'(bus.uart_tx), 32'd1);
        chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb), 32'd0);
        chk("rst_we", 32'(bus.wb_we), 32'd0);
        chk("rst_adr", 32'(bus.wb_adr), 32'd0);
        chk("rst_dat_w", bus.wb_dat_w, 32'd0);
        chk("rst_sel", 32'(bus.wb_sel), 32'hF);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(10);

        for (int v = 0; v < 6; v++) begin
            clear_logs();
            if (!vt[v].wr) begin
                rd_q.push_back(vt[v].d0);
                rd_q.push_back(vt[v].d1);
            end
            send_frame(vt[v].wr, vt[v].len, vt[v].addr, vt[v].d0, vt[v].d1);
            if (vt[v].len == 8'd0) idle(300);
            else wait_for(int'(vt[v].len), vt[v].wr ? 0 : 4 * int'(vt[v].len), 4000);
            idle(60);
            chk($sformatf("v%0d_bus_count", v), 32'(log_adr.size()), 32'(vt[v].len));
            chk($sformatf("v%0d_tx_count", v), 32'(tx_q.size()), vt[v].wr ? 32'd0 : 32'(4 * int'(vt[v].len)));
            for (int w = 0; w < int'(vt[v].len) && w < log_adr.size(); w++) begin
                ea = (w == 0) ? vt[v].ea0 : vt[v].ea1;
                ed = (w == 0) ? vt[v].d0 : vt[v].d1;
                chk($sformatf("v%0d_w%0d_adr", v, w), 32'(log_adr[w]), 32'(ea));
                chk($sformatf("v%0d_w%0d_we", v, w), 32'(log_we[w]), 32'(vt[v].wr));
                chk($sformatf("v%0d_w%0d_sel", v, w), 32'(log_sel[w]), 32'hF);
                if (vt[v].wr) chk($sformatf("v%0d_w%0d_dat_w", v, w), log_dat[w], ed);
                else for (int b = 0; b < 4 && 4 * w + b < tx_q.size(); b++)
                    chk($sformatf("v%0d_w%0d_tx%0d", v, w, b), 32'(tx_q[4*w+b]), 32'(ed[31-8*b -: 8]));
            end
        end

        clear_logs();
        send(8'h55, 1'b1);
        send(8'h01, 1'b0);
        idle(20);
        send_frame(1'b1, 8'd1, 32'h0400_0000, 32'h1234_5678, 32'h0);
        wait_for(1, 0, 3000);
        idle(100);
        chk("garbage_bus_count", 32'(log_adr.size()), 32'd1);
        if (log_adr.size() > 0) begin
            chk("garbage_adr", 32'(log_adr[0]), 32'h400_0000);
            chk("garbage_we", 32'(log_we[0]), 32'd1);
            chk("garbage_dat_w", log_dat[0], 32'h1234_5678);
        end

        clear_logs();
        hold_ack = 1'b1;
        send_frame(1'b1, 8'd1, 32'h0400_0000, 32'h1234_5678, 32'h0);
        for (int c = 0; c < 3000 && !bus.wb_cyc; c++) @(posedge clk);
        #1;
        chk("rst_test_cyc_up", 32'(bus.wb_cyc), 32'd1);
        chk("rst_test_we_up", 32'(bus.wb_we), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_test_cyc_drop", 32'(bus.wb_cyc), 32'd0);
        chk("rst_test_stb_drop", 32'(bus.wb_stb), 32'd0);
        rst = 1'b0;
        stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        hold_ack = 1'b0;
        chk("rst_test_stray_ack", 32'(bus.wb_cyc), 32'd0);
        idle(20);
        rd_q.push_back(32'h1234_5678);
        send_frame(1'b0, 8'd1, 32'h0400_0003, 32'h0, 32'h0);
        wait_for(1, 4, 4000);
        idle(60);
        check_read("rst_test_read", 30'h400_0003, 32'h1234_5678);

        clear_logs();
        rd_q.push_back(32'h1234_5678);
        send(8'h01, 1'b1);
        send(8'h01, 1'b1);
        send(8'h04, 1'b1);
        idle(1200);
        send_frame(1'b0, 8'd1, 32'h0400_0003, 32'h0, 32'h0);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        wait_for(1, 4, 4000);
        idle(60);
        check_read("timeout_read", 30'h400_0003, 32'h1234_5678);
`else
        idle(1500);
        chk("stall_bus_count", 32'(log_adr.size()), 32'd0);
        chk("stall_tx_count", 32'(tx_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5: clk cycles per UART bit. 8N1 framing, LSB first.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: inter-byte idle limit. Used only under REQ-031.
REQ-003 clk  in  1  single clock domain; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 uart_rx  in  1  serial input, idle high, asynchronous to clk.
REQ-006 uart_tx  out  1  serial output, idle high.
REQ-007 wb_adr  out  30  Wishbone word address.
REQ-008 wb_dat_w  out  32  write data.
REQ-009 wb_dat_r  in  32  read data.
REQ-010 wb_sel  out  4  byte select, constant 4'hF.
REQ-011 wb_cyc, wb_stb, wb_we  out  1 each  classic Wishbone cycle controls.
REQ-012 wb_ack  in  1  cycle termination.

Function
REQ-013 RX shall pass uart_rx through a two-flop synchronizer, detect the start-bit falling edge, and sample each bit at mid-bit (CLKS_PER_BIT/2 after the bit edge).
REQ-014 RX shall drop a byte whose stop bit samples low (framing error); the FSM does not see it.
REQ-015 RX shall hold each good byte in a one-entry buffer until the FSM consumes it; a byte completing while the buffer is full shall be dropped (overrun), and the buffered byte shall be kept.
REQ-016 Frame format: cmd byte, len byte, 4 address bytes MSB first (word address, bits 31:30 ignored), then for cmd 0x01, len x 4 data bytes, each word MSB first.
REQ-017 FSM states: IDLE, LEN, ADDR, WDATA, BUS_WR, BUS_RD, TX_DATA.
REQ-018 IDLE: byte 0x01 or 0x02 -> LEN. Any other byte shall be discarded, and the FSM stays in IDLE.
REQ-019 LEN shall latch the count -> ADDR. ADDR -> after 4th byte: write -> WDATA, read -> BUS_RD. If len=0, the FSM shall go to IDLE after ADDR with no bus cycle.
REQ-020 WDATA: after 4th byte -> BUS_WR.
REQ-021 BUS_WR and BUS_RD shall assert wb_cyc and wb_stb (wb_we=1 for write) the cycle after entry, and hold them until wb_ack. Both shall deassert in the cycle following ack. There is no bus timeout.
REQ-022 BUS_RD shall capture wb_dat_r on ack -> TX_DATA. TX_DATA shall send 4 bytes MSB first, each as 1 start bit, 8 data bits and 1 stop bit of CLKS_PER_BIT cycles.
REQ-023 After each word the address shall increment by 1, wrapping modulo 2^30, and the remaining count shall decrement. At count 0 -> IDLE, else -> WDATA (write) or BUS_RD (read).
REQ-024 Bytes received during BUS_RD/TX_DATA, or beyond a write's len x 4, shall be consumed in IDLE as the next command.

Reset
REQ-025 Reset values: uart_tx=1, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, FSM=IDLE, RX buffer empty, counters 0.
REQ-026 Reset mid-bus-cycle shall drop wb_cyc/wb_stb in the next cycle and abandon the transaction; a later ack shall be ignored.
REQ-027 Reset mid-TX shall force uart_tx high in the next cycle, truncating the byte.
REQ-028 Reset mid-RX byte shall discard the partial byte. RX shall re-arm only on a new falling edge seen after uart_rx has been high.

Configuration
REQ-029 Macro UART_WB_BRIDGE_TIMEOUT_EN.
REQ-030 Undefined: the FSM waits indefinitely between bytes of a frame.
REQ-031 Defined: in LEN, ADDR or WDATA, if TIMEOUT_CYCLES clk cycles pass without a good byte, the FSM shall return to IDLE and discard the partial frame. No bus cycle shall occur for a partial word; words already written stay written.

Verification
REQ-032 Write: 01 01 04 00 00 00 12 34 56 78 -> one cycle with wb_adr=0x4000000, wb_we=1, wb_dat_w=0x12345678, wb_sel=F.
REQ-033 Read: 02 01 04 00 00 03, slave returns 0x12345678 -> wb_adr=0x4000003, uart_tx bytes 12 34 56 78.
REQ-034 Burst: 02 02 3F FF FF FF, slave data FACECA8C then 0A0A0A0A -> wb_adr 0x3FFFFFFF then 0x0000000 (wrap); tx FA CE CA 8C 0A 0A 0A 0A.
REQ-035 Garbage then valid: 55, then a framing-error byte, then REQ-032 frame -> exactly one bus write with the REQ-032 values.
REQ-036 Reset: assert rst during BUS_WR with ack withheld -> wb_cyc=0 next cycle; a following REQ-033 frame shall complete correctly.
REQ-037 Timeout, macro defined, TIMEOUT_CYCLES=1000: 01 01 04, idle 1200 cycles, then REQ-033 frame -> only the read occurs. Macro undefined, same stimulus -> no read cycle occurs (bytes are taken as address/data of the stalled write).
